// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - sequential shift-add multiplier with unsigned/signed mode
//
// Purpose:
//   Computes m1 * m2 one partial product per clock. The run takes WIDTH
//   iterations after the capture edge. In signed mode the datapath works on
//   operand magnitudes. The sign is reapplied once, at completion.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active-high
//   start        request, sampled only while idle
//   signed_mode  1: two's complement operands, 0: unsigned (captured with start)
//   m1           multiplier (captured with start)
//   m2           multiplicand (captured with start)
//   busy         high while an operation is in progress
//   done         one-cycle pulse in the cycle product is updated
//   product      2*WIDTH-bit result, held until the next completion
module multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   m1,
  input  logic [WIDTH-1:0]   m2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    result;

  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). As an unsigned WIDTH-bit
  // value this still fits, so plain negation cannot overflow here.
  always_comb begin
    mag1   = (signed_mode && m1[WIDTH-1]) ? -m1 : m1;
    mag2   = (signed_mode && m2[WIDTH-1]) ? -m2 : m2;
    sum    = acc + (mplier[0] ? mcand : '0);
    // Negating zero gives zero, so a zero product never picks up a sign.
    result = neg ? -sum : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mplier  <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mplier <= mag1;
            mcand  <= {{WIDTH{1'b0}}, mag2};
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
            neg    <= signed_mode & (m1[WIDTH-1] ^ m2[WIDTH-1]);
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= sum;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt - CW'(1);
          // cnt == 0 marks the last iteration, so sum already holds the full magnitude.
          if (cnt == '0) begin
            product <= result;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// tb/tb_multiplier_seq.sv - self-checking bench for multiplier_seq at WIDTH 4, 8 and 16
module tb_multiplier_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start4 = 0, sm4 = 0;
  logic [3:0]  a4 = 0, b4 = 0;
  logic        busy4, done4;
  logic [7:0]  p4;

  logic        start8 = 0, sm8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8;
  logic [15:0] p8;

  logic        start16 = 0, sm16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        busy16, done16;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiplier_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .m1(a4), .m2(b4),
    .busy(busy4), .done(done4), .product(p4));
  multiplier_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .m1(a8), .m2(b8),
    .busy(busy8), .done(done8), .product(p8));
  multiplier_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .m1(a16), .m2(b16),
    .busy(busy16), .done(done16), .product(p16));

  typedef struct {
    int     w;
    bit     sm;
    longint a;
    longint b;
    longint exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the mathematical product of the operands read as signed or
  // unsigned integers, reduced modulo 2^(2w).
  function automatic longint ref_mul(int w, bit sm, longint a, longint b);
    longint mask = (longint'(1) << w) - 1;
    longint x = a & mask;
    longint y = b & mask;
    if (sm && x[w-1]) x = x - (longint'(1) << w);
    if (sm && y[w-1]) y = y - (longint'(1) << w);
    return (x * y) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic set_in(int w, bit st, bit sm, longint a, longint b);
    case (w)
      4:  begin start4 = st;  sm4 = sm;  a4 = a[3:0];   b4 = b[3:0];   end
      8:  begin start8 = st;  sm8 = sm;  a8 = a[7:0];   b8 = b[7:0];   end
      default: begin start16 = st; sm16 = sm; a16 = a[15:0]; b16 = b[15:0]; end
    endcase
  endtask

  function automatic bit get_busy(int w);
    return (w == 4) ? busy4 : (w == 8) ? busy8 : busy16;
  endfunction

  function automatic bit get_done(int w);
    return (w == 4) ? done4 : (w == 8) ? done8 : done16;
  endfunction

  function automatic longint get_prod(int w);
    return (w == 4) ? longint'(p4) : (w == 8) ? longint'(p8) : longint'(p16);
  endfunction

  // Called on the falling edge just after the capture edge. Returns the
  // number of cycles until done is seen and how many samples had busy high.
  task automatic wait_done(int w, output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    forever begin
      if (get_busy(w)) bc++;
      @(negedge clk);
      cyc++;
      if (get_done(w) || cyc > 100) break;
    end
  endtask

  // One full operation. The operands are scrambled after capture, so a
  // design that keeps reading the inputs during the run produces a wrong result.
  task automatic run_op(int w, bit sm, longint a, longint b,
                        output longint p, output int cyc, output int bc);
    set_in(w, 1'b1, sm, a, b);
    @(negedge clk);
    set_in(w, 1'b0, ~sm, longint'($urandom), longint'($urandom));
    wait_done(w, cyc, bc);
    p = get_prod(w);
  endtask

  initial begin
    longint p, a, b, mask;
    int cyc, bc, seen;
    bit sm;

    vecs[0] = '{4,  1'b0, 64'hF,    64'hF,    64'hE1};
    vecs[1] = '{4,  1'b1, 64'hF,    64'hF,    64'h01};
    vecs[2] = '{4,  1'b1, 64'h8,    64'h7,    64'hC8};
    vecs[3] = '{8,  1'b1, 64'h80,   64'h80,   64'h4000};
    vecs[4] = '{8,  1'b1, 64'hFD,   64'h05,   64'hFFF1};
    vecs[5] = '{8,  1'b1, 64'h00,   64'hF9,   64'h0000};
    vecs[6] = '{8,  1'b0, 64'hFF,   64'hFF,   64'hFE01};
    vecs[7] = '{16, 1'b1, 64'h8000, 64'h8000, 64'h40000000};
    vecs[8] = '{16, 1'b0, 64'hFFFF, 64'hFFFF, 64'hFFFE0001};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", longint'({busy4, busy8, busy16}), 0);
    check("reset_done", longint'({done4, done8, done16}), 0);
    check("reset_prod", get_prod(4) | get_prod(8) | get_prod(16), 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].w, vecs[i].sm, vecs[i].a, vecs[i].b, p, cyc, bc);
      check($sformatf("vec%0d_prod", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), cyc, vecs[i].w);
      check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].w);
      check($sformatf("vec%0d_busy_at_done", i), get_busy(vecs[i].w), 0);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), get_done(vecs[i].w), 0);
      check($sformatf("vec%0d_prod_held", i), get_prod(vecs[i].w), vecs[i].exp);
    end

    // Start while busy is ignored.
    set_in(8, 1'b1, 1'b0, 3, 4);
    @(negedge clk);
    set_in(8, 1'b1, 1'b0, 9, 9);
    @(negedge clk);
    set_in(8, 1'b0, 1'b0, 9, 9);
    wait_done(8, cyc, bc);
    check("busy_restart_prod", get_prod(8), 12);
    check("busy_restart_latency", cyc + 1, 8);
    // Start in the done cycle is accepted; product holds the old value meanwhile.
    set_in(8, 1'b1, 1'b0, 2, 2);
    @(negedge clk);
    set_in(8, 1'b0, 1'b0, 0, 0);
    check("done_start_busy", busy8, 1);
    check("done_start_prod_held", p8, 12);
    wait_done(8, cyc, bc);
    check("done_start_prod", p8, 4);
    check("done_start_latency", cyc, 8);

    // Reset mid-run aborts the operation.
    set_in(8, 1'b1, 1'b0, 7, 9);
    @(negedge clk);
    set_in(8, 1'b0, 1'b0, 7, 9);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_prod", p8, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    check("abort_no_done", seen, 0);
    run_op(8, 1'b0, 6, 7, p, cyc, bc);
    check("after_abort_prod", p, 42);

    // Reset wins over start in the same cycle.
    rst = 1'b1;
    set_in(8, 1'b1, 1'b0, 5, 5);
    @(negedge clk);
    rst = 1'b0;
    set_in(8, 1'b0, 1'b0, 0, 0);
    check("rst_priority_busy", busy8, 0);
    @(negedge clk);
    check("rst_priority_idle", busy8, 0);
    check("rst_priority_prod", p8, 0);

    // Randomised comparison against the arithmetic reference.
    for (int wi = 0; wi < 3; wi++) begin
      int w;
      w = (wi == 0) ? 4 : (wi == 1) ? 8 : 16;
      mask = (longint'(1) << w) - 1;
      for (int n = 0; n < 1000; n++) begin
        sm = 1'($urandom_range(1));
        a = longint'($urandom) & mask;
        b = longint'($urandom) & mask;
        case ($urandom_range(7))
          0: a = longint'(1) << (w - 1);
          1: b = mask;
          2: b = 0;
          default: ;
        endcase
        run_op(w, sm, a, b, p, cyc, bc);
        check($sformatf("rand_w%0d_sm%0d_%0h_x_%0h", w, sm, a, b), p, ref_mul(w, sm, a, b));
        check($sformatf("rand_w%0d_latency", w), cyc, w);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
